dec_char_tx: RTL and testbench
==============================

# dec_char_tx

Encoder-side counterpart to the character-stream solvers. Accepts a binary result value over a valid/ready handshake and converts it to decimal with an iterative double-dabble. Emits the value as ASCII digits, most significant first, with no leading zeros, followed by a newline, on a byte-wide valid/ready character stream. It sits after a solver's `result` output and drives a UART/log sink or a checker that consumes the same char stream format solvers consume.

## Interface
- `WIDTH`, 64, bit width of the input value.
- `DIGITS`, 20, BCD digit count; must satisfy 10^DIGITS > 2^WIDTH − 1.
- `EMIT_TERM`, 1, when 1 a terminator byte follows the last digit.
- `TERM_CHAR`, 8'd10, terminator byte value.
- `clk  input  1` — single clock, rising edge.
- `rst_n  input  1` — reset, asynchronous, active-low.
- `value_in  input  WIDTH` — binary value to print.
- `value_valid  input  1` — value_in is presented.
- `value_ready  output  1` — block can accept a value.
- `char_out  output  8` — ASCII byte.
- `char_valid  output  1` — char_out is presented.
- `char_ready  input  1` — sink accepts char_out.
- `busy  output  1` — a value is being converted or emitted.

## Operation
- State machine with states IDLE, CONVERT, SKIP, EMIT, TERM.
- **IDLE**
  - `value_ready=1`.
  - On `value_valid && value_ready`: latch value_in into the shift register, clear the BCD register (4·DIGITS bits), load the bit counter with WIDTH, and go to CONVERT.
- **CONVERT**
  - One bit per cycle: every BCD nibble ≥5 gets +3, then {bcd, shift} shifts left by 1.
  - The counter decrements. After WIDTH cycles, go to SKIP.
- **SKIP**
  - One cycle. A priority encoder finds the index of the most significant nonzero nibble and loads the digit pointer with it.
  - An all-zero BCD value gives pointer 0, so "0" is printed.
  - Go to EMIT.
- **EMIT**
  - `char_valid=1`, `char_out = 8'h30 + bcd[ptr]`.
  - On `char_ready`: if ptr==0, go to TERM (EMIT_TERM=1) or IDLE (EMIT_TERM=0); otherwise decrement ptr.
- **TERM**
  - `char_valid=1`, `char_out=TERM_CHAR`.
  - On `char_ready`, go to IDLE.
- Output relations:
  - `busy` = state≠IDLE.
  - `value_ready` = state==IDLE.
  - char_out and char_valid are registered.
- Arithmetic: add-3 is applied to 4-bit nibbles only, with no carry between nibbles. The shift register and counter are unsigned.
- Reset values: state IDLE, `value_ready=1`, `busy=0`, `char_valid=0`, `char_out=8'h00`, BCD/shift/pointer/counter registers 0.

## Timing
- Accept edge = E0. CONVERT occupies cycles E0+1..E0+WIDTH; SKIP is at E0+WIDTH+1.
- char_valid first rises at E0+WIDTH+2 (66 cycles for WIDTH=64).
- With char_ready held high, one byte transfers per cycle. `value_ready` rises in the cycle after the last byte's handshake edge.
- Backpressure:
  - While `char_valid && !char_ready`, char_out and char_valid hold.
  - The block never drops a byte or presents one twice.
  - char_valid never deasserts without a handshake.
- value_valid during busy is ignored; value_in is only sampled at the accept edge. Upstream must hold value_valid until the handshake.
- rst_n assertion at any state, mid-conversion or mid-emission:
  - All outputs take their reset values immediately, with no further bytes.
  - After release, the next accepted value prints in full.
- value_valid presented in the same cycle value_ready re-rises is accepted normally, which makes back-to-back values legal.

## Structure
- Shared package `aoc_pkg`:
  - `tx_state_t` enum {IDLE, CONVERT, SKIP, EMIT, TERM}.
  - Constants `ASCII_ZERO=8'd48`, `ASCII_NL=8'd10`.
- Sub-module `bcd_adj3`: a combinational 4-bit nibble → nibble+3 if ≥5, instantiated DIGITS times via generate.
- The priority encoder for SKIP stays inline.

## Test plan
- value 0 → bytes 8'h30, 8'h0A; first char_valid at E0+66; value_ready=1 the cycle after 8'h0A handshake.
- value 54338, char_ready=1 → "5","4","3","3","8","\n" on 6 consecutive cycles.
- value 2^64−1 → 20 digits "18446744073709551615" then 8'h0A (checks DIGITS=20 and no overflow of the top nibble).
- value 907, char_ready held low 5 cycles while "0" is presented → char_out=8'h30 stable throughout; full stream "907\n" with no duplicates.
- value_valid held high with values 7 then 10, second presented during busy → accepted only after "\n"; stream "7\n10\n".
- rst_n pulsed low while emitting the 3rd digit of 123456 → char_valid=0 and busy=0 immediately. Then value 42 → "42\n".

Source files
------------

// File: rtl/aoc_pkg.sv
`default_nettype none
// aoc_pkg: types and ASCII constants shared by the character-stream blocks.
// Rev 1.0
package aoc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CONVERT = 3'd1,
      SKIP    = 3'd2,
      EMIT    = 3'd3,
      TERM    = 3'd4
   } tx_state_t;

   localparam logic [7:0] ASCII_ZERO = 8'd48;
   localparam logic [7:0] ASCII_NL   = 8'd10;

endpackage
`default_nettype wire

// File: rtl/dec_char_tx_if.sv
`default_nettype none
// dec_char_tx_if: value-in handshake plus byte-wide char stream out.
// Rev 1.0
interface dec_char_tx_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-1:0] value_in;
   logic             value_valid;
   logic             value_ready;
   logic [7:0]       char_out;
   logic             char_valid;
   logic             char_ready;
   logic             busy;

   modport master (
      output value_in, value_valid, char_ready,
      input  value_ready, char_out, char_valid, busy
   );

   modport slave (
      input  value_in, value_valid, char_ready,
      output value_ready, char_out, char_valid, busy
   );
endinterface
`default_nettype wire

// File: rtl/bcd_adj3.sv
`default_nettype none
// bcd_adj3: double-dabble nibble correction, adds 3 when the digit is 5 or more.
// Rev 1.0
module bcd_adj3 (
   input  logic [3:0] nibble,
   output logic [3:0] adjusted
);
   assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
endmodule
`default_nettype wire

// File: rtl/dec_char_tx.sv
`default_nettype none
// dec_char_tx: binary value -> decimal ASCII digits (no leading zeros) + terminator.
// Rev 1.0
module dec_char_tx
   import aoc_pkg::*;
#(
   parameter int         WIDTH     = 64,
   parameter int         DIGITS    = 20,
   parameter bit         EMIT_TERM = 1'b1,
   parameter logic [7:0] TERM_CHAR = ASCII_NL
) (
   input  logic         clk,
   input  logic         rst_n,
   dec_char_tx_if.slave bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec, msd_idx;
   logic [7:0]       char_out_q, char_out_d;
   logic             char_valid_q, char_valid_d;
   logic [3:0]       msd_nib, next_nib;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_adj
         bcd_adj3 u_adj (
            .nibble   (bcd_q[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   // Highest nonzero nibble wins; an all-zero value leaves index 0 so "0" prints.
   always_comb begin
      msd_idx = '0;
      msd_nib = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            msd_idx = PTR_W'(i);
            msd_nib = bcd_q[4*i +: 4];
         end
      end
   end

   assign ptr_dec = ptr_q - 1'b1;

   always_comb begin
      next_nib = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (ptr_dec == PTR_W'(i)) begin
            next_nib = bcd_q[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      char_out_d   = char_out_q;
      char_valid_d = char_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.value_valid) begin
               shift_d = bus.value_in;
               bcd_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            // Top BCD bit is dropped; DIGITS is sized so it is always zero.
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = SKIP;
            end
         end
         SKIP: begin
            ptr_d        = msd_idx;
            char_out_d   = ASCII_ZERO + {4'd0, msd_nib};
            char_valid_d = 1'b1;
            state_d      = EMIT;
         end
         EMIT: begin
            if (bus.char_ready) begin
               if (ptr_q == '0) begin
                  if (EMIT_TERM) begin
                     char_out_d = TERM_CHAR;
                     state_d    = TERM;
                  end else begin
                     char_out_d   = 8'h00;
                     char_valid_d = 1'b0;
                     state_d      = IDLE;
                  end
               end else begin
                  ptr_d      = ptr_dec;
                  char_out_d = ASCII_ZERO + {4'd0, next_nib};
               end
            end
         end
         TERM: begin
            if (bus.char_ready) begin
               char_out_d   = 8'h00;
               char_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         ptr_q        <= '0;
         char_out_q   <= 8'h00;
         char_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         char_out_q   <= char_out_d;
         char_valid_q <= char_valid_d;
      end
   end

   assign bus.value_ready = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.char_out    = char_out_q;
   assign bus.char_valid  = char_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_char_tx.sv
`default_nettype none
// tb_dec_char_tx: directed checks of the decimal char transmitter.
// Rev 1.0
module tb_dec_char_tx;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   dec_char_tx_if #(.WIDTH(64)) bus ();

   dec_char_tx #(
      .WIDTH     (64),
      .DIGITS    (20),
      .EMIT_TERM (1'b1),
      .TERM_CHAR (8'd10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send(input logic [63:0] v, output bit ok);
      int n;
      n = 0;
      bus.value_in    = v;
      bus.value_valid = 1'b1;
      while (!bus.value_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      ok = bus.value_ready;
      @(posedge clk); #1;
      bus.value_valid = 1'b0;
   endtask

   task automatic get_byte(output logic [7:0] b, output int waited);
      waited = 0;
      bus.char_ready = 1'b1;
      while (!bus.char_valid && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (bus.char_valid) begin
         b = bus.char_out;
         @(posedge clk); #1;
      end else begin
         b = 8'hxx;
         waited = -1;
      end
   endtask

   task automatic test_reset();
      total++;
      if (bus.char_valid !== 1'b0 || bus.busy !== 1'b0 || bus.value_ready !== 1'b1 || bus.char_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_in: valid=%b busy=%b ready=%b out=%h want 0 0 1 00",
                  bus.char_valid, bus.busy, bus.value_ready, bus.char_out);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.char_valid !== 1'b0 || bus.busy !== 1'b0 || bus.value_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_after: valid=%b busy=%b ready=%b want 0 0 1",
                  bus.char_valid, bus.busy, bus.value_ready);
      end
   endtask

   task automatic test_zero();
      bit          ok;
      logic [7:0]  b;
      int          w;
      bus.char_ready = 1'b1;
      send(64'd0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL zero_accept: got not-ready want ready"); end
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b want 1", bus.busy); end
      for (int k = 1; k <= 65; k++) begin
         @(posedge clk); #1;
         if (k == 64) begin
            total++;
            if (bus.char_valid !== 1'b0) begin
               bad++; $display("FAIL zero_early_valid: got %b want 0 at edge 64", bus.char_valid);
            end
         end
      end
      total++;
      if (bus.char_valid !== 1'b1) begin
         bad++; $display("FAIL zero_first_valid: got %b want 1 at edge 65", bus.char_valid);
      end
      get_byte(b, w);
      total++;
      if (b !== 8'h30 || w != 0) begin bad++; $display("FAIL zero_digit: got %h/%0d want 30/0", b, w); end
      get_byte(b, w);
      total++;
      if (b !== 8'h0A || w != 0) begin bad++; $display("FAIL zero_term: got %h/%0d want 0a/0", b, w); end
      total++;
      if (bus.value_ready !== 1'b1 || bus.busy !== 1'b0 || bus.char_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_idle: ready=%b busy=%b valid=%b want 1 0 0",
                  bus.value_ready, bus.busy, bus.char_valid);
      end
   endtask

   task automatic test_stream(input logic [63:0] v, input string exp, input string name);
      bit          ok;
      logic [7:0]  b;
      int          w;
      bus.char_ready = 1'b1;
      send(v, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_accept: got not-ready want ready", name); end
      for (int i = 0; i < exp.len(); i++) begin
         get_byte(b, w);
         total++;
         if (b !== exp[i]) begin
            bad++; $display("FAIL %s_byte%0d: got %h want %h", name, i, b, exp[i]);
         end
         if (i > 0) begin
            total++;
            if (w != 0) begin bad++; $display("FAIL %s_gap%0d: got %0d idle cycles want 0", name, i, w); end
         end
      end
      total++;
      if (bus.char_valid !== 1'b0 || bus.value_ready !== 1'b1) begin
         bad++; $display("FAIL %s_end: valid=%b ready=%b want 0 1", name, bus.char_valid, bus.value_ready);
      end
   endtask

   task automatic test_backpressure();
      bit          ok;
      logic [7:0]  b;
      int          w;
      string       rest;
      rest = "07\n";
      bus.char_ready = 1'b1;
      send(64'd907, ok);
      get_byte(b, w);
      total++;
      if (b !== 8'h39) begin bad++; $display("FAIL bp_first: got %h want 39", b); end
      bus.char_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (bus.char_valid !== 1'b1 || bus.char_out !== 8'h30) begin
            bad++; $display("FAIL bp_hold%0d: valid=%b out=%h want 1 30", k, bus.char_valid, bus.char_out);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < rest.len(); i++) begin
         get_byte(b, w);
         total++;
         if (b !== rest[i] || w != 0) begin
            bad++; $display("FAIL bp_rest%0d: got %h/%0d want %h/0", i, b, w, rest[i]);
         end
      end
      total++;
      if (bus.char_valid !== 1'b0) begin bad++; $display("FAIL bp_extra: got valid=%b want 0", bus.char_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got[$];
      string      exp;
      int         n_acc;
      exp   = "7\n10\n";
      n_acc = 0;
      bus.char_ready  = 1'b1;
      bus.value_in    = 64'd7;
      bus.value_valid = 1'b1;
      for (int c = 0; c < 400 && got.size() < exp.len(); c++) begin
         if (bus.value_ready && bus.value_valid) begin
            n_acc++;
            if (n_acc == 2) begin
               total++;
               if (got.size() != 2) begin
                  bad++; $display("FAIL b2b_second_early: got %0d bytes before accept want 2", got.size());
               end
            end
         end
         if (bus.char_valid) got.push_back(bus.char_out);
         @(posedge clk); #1;
         if (n_acc == 1) bus.value_in = 64'd10;
         if (n_acc == 2) bus.value_valid = 1'b0;
      end
      bus.value_valid = 1'b0;
      total++;
      if (n_acc != 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
      total++;
      if (got.size() != exp.len()) begin
         bad++; $display("FAIL b2b_len: got %0d want %0d", got.size(), exp.len());
      end else begin
         for (int i = 0; i < exp.len(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
               bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit          ok;
      logic [7:0]  b;
      int          w;
      bus.char_ready = 1'b1;
      send(64'd123456, ok);
      get_byte(b, w);
      get_byte(b, w);
      total++;
      if (b !== 8'h32 || bus.char_out !== 8'h33 || bus.char_valid !== 1'b1) begin
         bad++; $display("FAIL rst_setup: got %h then %h/%b want 32 then 33/1", b, bus.char_out, bus.char_valid);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.char_valid !== 1'b0 || bus.busy !== 1'b0 || bus.value_ready !== 1'b1 || bus.char_out !== 8'h00) begin
         bad++;
         $display("FAIL rst_mid: valid=%b busy=%b ready=%b out=%h want 0 0 1 00",
                  bus.char_valid, bus.busy, bus.value_ready, bus.char_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.char_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL rst_quiet: valid=%b busy=%b want 0 0", bus.char_valid, bus.busy);
      end
      test_stream(64'd42, "42\n", "after_rst");
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      rst_n           = 1'b0;
      bus.value_in    = '0;
      bus.value_valid = 1'b0;
      bus.char_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_zero();
      test_stream(64'd54338, "54338\n", "v54338");
      test_stream(64'hFFFF_FFFF_FFFF_FFFF, "18446744073709551615\n", "max");
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
